// File: rtl/rgb_fade_sequencer.sv
// RGB palette fade sequencer: ramps R/G/B duty toward an 8-entry palette, holds, advances.
// Optional SEQ_GAMMA_EN adds a registered (v*v)>>CW perceptual map on the outputs.
module rgb_fade_sequencer #(
  parameter int CW         = 8,
  parameter int STEP       = 1,
  parameter int HOLD_TICKS = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic [3:1]    btn,
  output logic [CW-1:0] R_time_out,
  output logic [CW-1:0] G_time_out,
  output logic [CW-1:0] B_time_out,
  output logic [3:0]    led
);

  // state | meaning
  // IDLE  | stopped, outputs 0, idx 0
  // FADE  | stepping channels toward pal[idx] on each tick
  // HOLD  | at target, counting hold_cnt down on each tick
  // PAUSE | frozen; saved_state is resumed on start
  typedef enum logic [1:0] {IDLE, FADE, HOLD, PAUSE} state_t;

  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_TICKS - 1);
  localparam logic [CW-1:0] FULL      = {CW{1'b1}};
  localparam logic [CW:0]   STEP_W    = (CW+1)'(STEP);

  // one bit per palette index, bit i = channel full at idx i
  localparam logic [7:0] PAL_R = 8'b0110_0011;
  localparam logic [7:0] PAL_G = 8'b0100_1110;
  localparam logic [7:0] PAL_B = 8'b0111_1000;

  state_t          state, state_n, saved, saved_n;
  logic [2:0]      idx, idx_n;
  logic [CW-1:0]   r, g, b, r_n, g_n, b_n;
  logic [CW-1:0]   tgt_r, tgt_g, tgt_b, step_r, step_g, step_b;
  logic [HW-1:0]   hold_cnt, hold_n;
  logic [3:1]      btn_q, press;

  function automatic logic [CW-1:0] step_to(input logic [CW-1:0] cur, input logic [CW-1:0] tgt);
    logic [CW:0] d;
    if (tgt >= cur) d = {1'b0, tgt} - {1'b0, cur};
    else            d = {1'b0, cur} - {1'b0, tgt};
    if (d <= STEP_W)  return tgt;
    else if (tgt > cur) return cur + STEP_W[CW-1:0];
    else                return cur - STEP_W[CW-1:0];
  endfunction

  assign press  = btn & ~btn_q;
  assign tgt_r  = PAL_R[idx] ? FULL : '0;
  assign tgt_g  = PAL_G[idx] ? FULL : '0;
  assign tgt_b  = PAL_B[idx] ? FULL : '0;
  assign step_r = step_to(r, tgt_r);
  assign step_g = step_to(g, tgt_g);
  assign step_b = step_to(b, tgt_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      saved    <= IDLE;
      idx      <= '0;
      r        <= '0;
      g        <= '0;
      b        <= '0;
      hold_cnt <= '0;
      btn_q    <= '0;
    end else begin
      state    <= state_n;
      saved    <= saved_n;
      idx      <= idx_n;
      r        <= r_n;
      g        <= g_n;
      b        <= b_n;
      hold_cnt <= hold_n;
      btn_q    <= btn;
    end
  end

  always_comb begin
    state_n = state;
    saved_n = saved;
    idx_n   = idx;
    r_n     = r;
    g_n     = g;
    b_n     = b;
    hold_n  = hold_cnt;
    if (press[3]) begin
      state_n = IDLE;
      idx_n   = '0;
      r_n     = '0;
      g_n     = '0;
      b_n     = '0;
    end else if (press[2]) begin
      case (state)
        FADE, HOLD: begin
          idx_n   = idx + 3'd1;
          state_n = FADE;
        end
        PAUSE: begin
          idx_n   = idx + 3'd1;
          saved_n = FADE;
        end
        default: ;
      endcase
    end else if (press[1]) begin
      case (state)
        IDLE:       state_n = FADE;
        FADE, HOLD: begin
          saved_n = state;
          state_n = PAUSE;
        end
        PAUSE:      state_n = saved;
        default:    ;
      endcase
    end else if (tick) begin
      case (state)
        FADE: begin
          r_n = step_r;
          g_n = step_g;
          b_n = step_b;
          if (step_r == tgt_r && step_g == tgt_g && step_b == tgt_b) begin
            state_n = HOLD;
            hold_n  = HOLD_LOAD;
          end
        end
        HOLD: begin
          if (hold_cnt == '0) begin
            idx_n   = idx + 3'd1;
            state_n = FADE;
          end else begin
            hold_n = hold_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign led = {(state == FADE) || (state == HOLD), idx};

`ifdef SEQ_GAMMA_EN
  function automatic logic [CW-1:0] gamma(input logic [CW-1:0] v);
    logic [2*CW-1:0] p;
    p = {{CW{1'b0}}, v} * {{CW{1'b0}}, v};
    return CW'(p >> CW);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      R_time_out <= '0;
      G_time_out <= '0;
      B_time_out <= '0;
    end else begin
      R_time_out <= gamma(r);
      G_time_out <= gamma(g);
      B_time_out <= gamma(b);
    end
  end
`else
  assign R_time_out = r;
  assign G_time_out = g;
  assign B_time_out = b;
`endif

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Bench for rgb_fade_sequencer: two instances (STEP=51 and STEP=100) checked every clock
// against a flag-based palette model, with directed scenarios followed by random buttons/ticks.
module tb_rgb_fade_sequencer;
  localparam int CW = 8;
  localparam int HT = 4;

  logic       clk = 1'b0;
  logic       rst, tick;
  logic [3:1] btn;
  logic [7:0] r0, g0, b0, r1, g1, b1;
  logic [3:0] led0, led1;

  rgb_fade_sequencer #(.CW(CW), .STEP(51), .HOLD_TICKS(HT)) dut_s51 (
    .clk(clk), .rst(rst), .tick(tick), .btn(btn),
    .R_time_out(r0), .G_time_out(g0), .B_time_out(b0), .led(led0));

  rgb_fade_sequencer #(.CW(CW), .STEP(100), .HOLD_TICKS(HT)) dut_s100 (
    .clk(clk), .rst(rst), .tick(tick), .btn(btn),
    .R_time_out(r1), .G_time_out(g1), .B_time_out(b1), .led(led1));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int pal_tab [8][3] = '{'{255,0,0}, '{255,255,0}, '{0,255,0}, '{0,255,255},
                         '{0,0,255}, '{255,0,255}, '{255,255,255}, '{0,0,0}};

  // model: running/paused/holding flags, ticks left in hold, channel values
  bit         m_run [2];
  bit         m_paused [2];
  bit         m_holding [2];
  int         m_idx [2];
  int         m_left [2];
  int         m_ch [2][3];
  int         m_old [2][3];
  logic [3:1] m_prev [2];

  task automatic model_clk(input int k, input bit rs, input logic [3:1] bv, input bit t, input int step);
    logic [3:1] p;
    bit done;
    for (int c = 0; c < 3; c++) m_old[k][c] = m_ch[k][c];
    if (rs) begin
      m_run[k] = 0; m_paused[k] = 0; m_holding[k] = 0;
      m_idx[k] = 0; m_left[k] = 0; m_prev[k] = '0;
      for (int c = 0; c < 3; c++) m_ch[k][c] = 0;
      return;
    end
    p = bv & ~m_prev[k];
    m_prev[k] = bv;
    if (p[3]) begin
      m_run[k] = 0; m_paused[k] = 0; m_holding[k] = 0; m_idx[k] = 0;
      for (int c = 0; c < 3; c++) m_ch[k][c] = 0;
    end else if (p[2]) begin
      if (m_run[k]) begin
        m_idx[k] = (m_idx[k] + 1) % 8;
        m_holding[k] = 0;
      end
    end else if (p[1]) begin
      if (!m_run[k]) begin
        m_run[k] = 1; m_paused[k] = 0; m_holding[k] = 0;
      end else begin
        m_paused[k] = !m_paused[k];
      end
    end else if (t && m_run[k] && !m_paused[k]) begin
      if (m_holding[k]) begin
        m_left[k]--;
        if (m_left[k] == 0) begin
          m_idx[k] = (m_idx[k] + 1) % 8;
          m_holding[k] = 0;
        end
      end else begin
        done = 1;
        for (int c = 0; c < 3; c++) begin
          int tg, diff;
          tg = pal_tab[m_idx[k]][c];
          diff = tg - m_ch[k][c];
          if (diff <= step && diff >= -step) m_ch[k][c] = tg;
          else m_ch[k][c] += (diff > 0) ? step : -step;
          if (m_ch[k][c] != tg) done = 0;
        end
        if (done) begin
          m_holding[k] = 1;
          m_left[k] = HT;
        end
      end
    end
  endtask

  function automatic int exp_out(input int k, input int c);
`ifdef SEQ_GAMMA_EN
    return (m_old[k][c] * m_old[k][c]) >> CW;
`else
    return m_ch[k][c];
`endif
  endfunction

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      logic [7:0] rr, gg, bb;
      logic [3:0] ll;
      rr = (k == 0) ? r0 : r1;
      gg = (k == 0) ? g0 : g1;
      bb = (k == 0) ? b0 : b1;
      ll = (k == 0) ? led0 : led1;
      check($sformatf("R%0d", k), rr, exp_out(k, 0));
      check($sformatf("G%0d", k), gg, exp_out(k, 1));
      check($sformatf("B%0d", k), bb, exp_out(k, 2));
      check($sformatf("LED%0d", k), ll,
            {(m_run[k] && !m_paused[k]) ? 1'b1 : 1'b0, 3'(m_idx[k])});
    end
  endtask

  task automatic cyc(input bit rs, input logic [3:1] bv, input bit t);
    rst = rs; btn = bv; tick = t;
    @(posedge clk);
    #1;
    model_clk(0, rs, bv, t, 51);
    model_clk(1, rs, bv, t, 100);
    compare_all();
  endtask

  task automatic press(input logic [3:1] bv);
    cyc(0, bv, 0);
    cyc(0, 3'b000, 0);
  endtask

  task automatic ticks(input int n);
    repeat (n) cyc(0, 3'b000, 1);
  endtask

  initial begin
    logic [3:1] bv;
    rst = 1'b1; btn = '0; tick = 1'b0;
    cyc(1, 3'b000, 0);
    cyc(1, 3'b000, 1);
    check("reset_led", led0, 4'b0000);
    check("reset_r", r0, 0);

    press(3'b001);
    check("start_led", led0, 4'b1000);
    ticks(1);
`ifndef SEQ_GAMMA_EN
    check("fade1_r51", r0, 51);
    check("fade1_r100", r1, 100);
`endif
    ticks(2);
`ifndef SEQ_GAMMA_EN
    check("fade3_r51", r0, 153);
    check("fade3_r100_sat", r1, 255);
`endif
    ticks(2);
`ifndef SEQ_GAMMA_EN
    check("fade5_r51", r0, 255);
    check("fade5_g51", g0, 0);
`endif
    check("arrive_led", led0, 4'b1000);
    ticks(4);
    check("hold_done_led", led0, 4'b1001);
    ticks(5);
`ifndef SEQ_GAMMA_EN
    check("g_ramp_g", g0, 255);
    check("g_ramp_r", r0, 255);
`endif
    ticks(40);

    press(3'b100);
    check("stop_led", led0, 4'b0000);
    press(3'b001);
    ticks(2);
    press(3'b010);
    check("skip_led", led0, 4'b1001);
    ticks(1);
`ifndef SEQ_GAMMA_EN
    check("skip_r", r0, 153);
    check("skip_g", g0, 51);
`endif
    press(3'b001);
    ticks(3);
    check("pause_led", led0, 4'b0001);
`ifndef SEQ_GAMMA_EN
    check("pause_r", r0, 153);
`endif
    press(3'b001);
    ticks(1);
`ifndef SEQ_GAMMA_EN
    check("resume_r", r0, 204);
`endif
    press(3'b010);
    press(3'b001);
    press(3'b010);
    press(3'b001);
    ticks(100);

    press(3'b100);
    press(3'b001);
    ticks(2);
    cyc(0, 3'b110, 1);
    cyc(0, 3'b000, 0);
    check("stopskip_led", led0, 4'b0000);
    check("stopskip_r", r0, 0);

    press(3'b001);
    ticks(6);
    cyc(1, 3'b000, 1);
    check("rst_hold_led", led0, 4'b0000);
    check("rst_hold_r", r0, 0);
    cyc(1, 3'b000, 0);

    bv = '0;
    repeat (3000) begin
      if ($urandom_range(0, 15) == 0) begin
        int sel;
        sel = $urandom_range(0, 99);
        if (sel < 50)      bv[1] = ~bv[1];
        else if (sel < 85) bv[2] = ~bv[2];
        else               bv[3] = ~bv[3];
      end
      cyc($urandom_range(0, 599) == 0, bv, $urandom_range(0, 2) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
